// File: rtl/mips8_shift_seq_if.sv
// mips8_shift_seq_if: request/result handshake bundle for the sequential shift engine
interface mips8_shift_seq_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] data_in;
  logic [2:0] shamt;
  logic [1:0] switch;
  logic       arith;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic       busy;
  modport master (
    output in_valid, data_in, shamt, switch, arith, out_ready,
    input  in_ready, out_valid, result, busy
  );
  modport slave (
    input  in_valid, data_in, shamt, switch, arith, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/mips8_shift_seq.sv
// mips8_shift_seq: 8-bit MIPS shifter that moves one bit position per clock
module mips8_shift_seq (
  input  logic             clk,
  input  logic             rst,
  mips8_shift_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t     state_q, state_d;
  logic [7:0] result_q, result_d, step;
  logic [2:0] count_q, count_d;
  logic [1:0] op_q, op_d;
  logic       arith_q, arith_d;
  assign step = op_q == 2'b01 ? {result_q[6:0], 1'b0} :
                op_q == 2'b10 ? {arith_q & result_q[7], result_q[7:1]} :
                op_q == 2'b11 ? {result_q[0], result_q[7:1]} : result_q;
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    count_d  = count_q;
    op_d     = op_q;
    arith_d  = arith_q;
    unique case (state_q)
      IDLE: if (bus.in_valid) begin
        result_d = bus.data_in;
        count_d  = bus.shamt;
        op_d     = bus.switch;
        arith_d  = bus.arith;
        state_d  = (bus.switch == 2'b00 || bus.shamt == 3'd0) ? DONE : SHIFT;
      end
      SHIFT: begin
        result_d = step;
        count_d  = count_q - 3'd1;
        state_d  = count_q == 3'd1 ? DONE : SHIFT;
      end
      DONE:    state_d = bus.out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      result_q <= 8'h00;
      count_q  <= 3'd0;
      op_q     <= 2'b00;
      arith_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      count_q  <= count_d;
      op_q     <= op_d;
      arith_q  <= arith_d;
    end
  end
  assign bus.in_ready  = state_q == IDLE;
  assign bus.out_valid = state_q == DONE;
  assign bus.busy      = state_q != IDLE;
  assign bus.result    = result_q;
endmodule

// File: tb/tb_mips8_shift_seq.sv
// tb_mips8_shift_seq: directed checks of latency, results, backpressure and reset
module tb_mips8_shift_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  mips8_shift_seq_if bus ();
  mips8_shift_seq dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  // Issues one request from a post-edge point; returns edges after acceptance
  // until out_valid, the result then, and the number of busy samples seen.
  task automatic do_op(input logic [7:0] d, input logic [2:0] sh, input logic [1:0] sw,
                       input logic ar, output int lat, output logic [7:0] res, output int bc);
    bus.in_valid = 1'b1;
    bus.data_in  = d;
    bus.shamt    = sh;
    bus.switch   = sw;
    bus.arith    = ar;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    bc  = bus.busy ? 1 : 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (bus.busy) bc++;
    end
    res = bus.result;
  endtask

  task automatic test_reset();
    logic seen;
    #2;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.result !== 8'h00) begin failures++; $display("FAIL reset_result got=%h exp=00", bus.result); end
    @(negedge clk) rst = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL reset_spurious_valid got=%b exp=0", seen); end
  endtask

  task automatic test_left();
    int lat, bc;
    logic [7:0] res;
    bus.out_ready = 1'b1;
    do_op(8'h81, 3'd3, 2'b01, 1'b0, lat, res, bc);
    checks++; if (res !== 8'h08) begin failures++; $display("FAIL left_result got=%h exp=08", res); end
    checks++; if (lat !== 3) begin failures++; $display("FAIL left_latency got=%0d exp=3", lat); end
    @(posedge clk); #1;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL left_busy_end got=%b exp=0", bus.busy); end
    checks++; if (bc !== 4) begin failures++; $display("FAIL left_busy_cycles got=%0d exp=4", bc); end
  endtask

  task automatic test_right();
    int lat, bc;
    logic [7:0] res;
    do_op(8'h90, 3'd2, 2'b10, 1'b1, lat, res, bc);
    checks++; if (res !== 8'hE4) begin failures++; $display("FAIL sra_result got=%h exp=e4", res); end
    checks++; if (lat !== 2) begin failures++; $display("FAIL sra_latency got=%0d exp=2", lat); end
    @(posedge clk); #1;
    do_op(8'h90, 3'd2, 2'b10, 1'b0, lat, res, bc);
    checks++; if (res !== 8'h24) begin failures++; $display("FAIL srl_result got=%h exp=24", res); end
    checks++; if (lat !== 2) begin failures++; $display("FAIL srl_latency got=%0d exp=2", lat); end
    @(posedge clk); #1;
  endtask

  task automatic test_rotate_bypass();
    int lat, bc;
    logic [7:0] res;
    do_op(8'h01, 3'd7, 2'b11, 1'b0, lat, res, bc);
    checks++; if (res !== 8'h02) begin failures++; $display("FAIL ror_result got=%h exp=02", res); end
    checks++; if (lat !== 7) begin failures++; $display("FAIL ror_latency got=%0d exp=7", lat); end
    @(posedge clk); #1;
    do_op(8'hA5, 3'd5, 2'b00, 1'b0, lat, res, bc);
    checks++; if (res !== 8'hA5) begin failures++; $display("FAIL bypass_result got=%h exp=a5", res); end
    checks++; if (lat !== 0) begin failures++; $display("FAIL bypass_latency got=%0d exp=0", lat); end
    @(posedge clk); #1;
    do_op(8'h3C, 3'd0, 2'b01, 1'b0, lat, res, bc);
    checks++; if (res !== 8'h3C) begin failures++; $display("FAIL zero_shamt_result got=%h exp=3c", res); end
    checks++; if (lat !== 0) begin failures++; $display("FAIL zero_shamt_latency got=%0d exp=0", lat); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int lat, bc;
    logic [7:0] res;
    bus.out_ready = 1'b0;
    do_op(8'h0F, 3'd1, 2'b01, 1'b0, lat, res, bc);
    checks++; if (res !== 8'h1E) begin failures++; $display("FAIL bp_result got=%h exp=1e", res); end
    bus.in_valid = 1'b1;
    bus.data_in  = 8'h55;
    bus.shamt    = 3'd2;
    bus.switch   = 2'b01;
    repeat (4) begin
      @(posedge clk); #1;
      checks++; if (bus.result !== 8'h1E) begin failures++; $display("FAIL bp_hold_result got=%h exp=1e", bus.result); end
      checks++; if ({bus.in_ready, bus.out_valid} !== 2'b01) begin failures++; $display("FAIL bp_hold_flags got=%b exp=01", {bus.in_ready, bus.out_valid}); end
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if ({bus.in_ready, bus.out_valid} !== 2'b10) begin failures++; $display("FAIL bp_idle_gap got=%b exp=10", {bus.in_ready, bus.out_valid}); end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL bp_second_accept got=%b exp=1", bus.busy); end
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++; if (bus.result !== 8'h54) begin failures++; $display("FAIL bp_second_result got=%h exp=54", bus.result); end
    checks++; if (lat !== 2) begin failures++; $display("FAIL bp_second_latency got=%0d exp=2", lat); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int lat, bc;
    logic [7:0] res;
    logic seen;
    bus.in_valid = 1'b1;
    bus.data_in  = 8'h80;
    bus.shamt    = 3'd6;
    bus.switch   = 2'b11;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    checks++; if (bus.result !== 8'h20) begin failures++; $display("FAIL mid_intermediate got=%h exp=20", bus.result); end
    #1 rst = 1'b1;
    #1;
    checks++; if (bus.result !== 8'h00) begin failures++; $display("FAIL mid_rst_result got=%h exp=00", bus.result); end
    checks++; if ({bus.in_ready, bus.busy, bus.out_valid} !== 3'b100) begin failures++; $display("FAIL mid_rst_flags got=%b exp=100", {bus.in_ready, bus.busy, bus.out_valid}); end
    seen = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b0) seen = 1'b1;
    end
    rst = 1'b0;
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL mid_rst_valid got=%b exp=0", seen); end
    do_op(8'hC3, 3'd4, 2'b10, 1'b0, lat, res, bc);
    checks++; if (res !== 8'h0C) begin failures++; $display("FAIL post_rst_result got=%h exp=0c", res); end
    checks++; if (lat !== 4) begin failures++; $display("FAIL post_rst_latency got=%0d exp=4", lat); end
    @(posedge clk); #1;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.data_in   = 8'h00;
    bus.shamt     = 3'd0;
    bus.switch    = 2'b00;
    bus.arith     = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_left();
    test_right();
    test_rotate_bypass();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
